// File: rtl/m6809_estretch_ctl_pkg.sv
// Shared phase encodings and default timing parameters for the 6809E E/Q clock generator.
package m6809_estretch_ctl_pkg;

  // Each phase value is the {E,Q} pin pair, so the clock pins can be driven straight from the phase register.
  typedef enum logic [1:0] {
    PH_P0 = 2'b00,
    PH_P1 = 2'b01,
    PH_P2 = 2'b11,
    PH_P3 = 2'b10
  } phase_t;

  localparam int SLOW_WAITS_DEF  = 2;
  localparam int MAX_STRETCH_DEF = 15;
  localparam int CW_DEF          = 4;

endpackage

// File: rtl/m6809_estretch_ctl_sync2.sv
// Two-flop synchroniser for an asynchronous level input; 2-clock latency.
// The reset value is a parameter, so an idle "ready" level is held while reset is asserted.
module m6809_estretch_ctl_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/m6809_estretch_ctl.sv
// 6809E E/Q quadrature clock generator. It stretches E-high (P3) for slow devices and for a low sys_mrdy.
// A watchdog on the stretch length forces the release of P3 and sets a sticky timeout flag.
module m6809_estretch_ctl
  import m6809_estretch_ctl_pkg::*;
#(
  parameter int SLOW_WAITS  = SLOW_WAITS_DEF,
  parameter int MAX_STRETCH = MAX_STRETCH_DEF,
  parameter int CW          = CW_DEF
) (
  input  logic clkin,
  input  logic rst,
  input  logic sys_mrdy,
  input  logic slow_sel,
  input  logic timeout_clr,
  output logic eclk,
  output logic qclk,
  output logic cycle_start,
  output logic stretching,
  output logic timeout
);

  localparam logic [CW-1:0] LP_SLOW = CW'(SLOW_WAITS);
  localparam logic [CW-1:0] LP_MAX  = CW'(MAX_STRETCH);
  localparam logic [CW-1:0] LP_ONE  = CW'(1);

  phase_t        r_phase;
  logic [CW-1:0] r_wait_cnt;
  logic [CW-1:0] r_stretch_cnt;
  logic          r_cycle_start;
  logic          r_stretching;
  logic          r_timeout;
  logic          w_mrdy_s;

  m6809_estretch_ctl_sync2 #(
    .RST_VAL (1'b1)
  ) u_mrdy_sync (
    .i_clk (clkin),
    .i_rst (rst),
    .i_d   (sys_mrdy),
    .o_q   (w_mrdy_s)
  );

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_phase       <= PH_P0;
      r_wait_cnt    <= '0;
      r_stretch_cnt <= '0;
      r_cycle_start <= 1'b0;
      r_stretching  <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_cycle_start <= 1'b0;
      r_stretching  <= 1'b0;
      if (timeout_clr) begin
        r_timeout <= 1'b0;
      end
      case (r_phase)
        PH_P0: r_phase <= PH_P1;
        PH_P1: r_phase <= PH_P2;
        PH_P2: begin
          r_phase       <= PH_P3;
          r_wait_cnt    <= slow_sel ? LP_SLOW : '0;
          r_stretch_cnt <= '0;
        end
        PH_P3: begin
          // The forced release is tested first, so the increments below never run at LP_MAX. The counter therefore saturates and cannot wrap.
          if (r_stretch_cnt == LP_MAX) begin
            r_phase       <= PH_P0;
            r_cycle_start <= 1'b1;
            r_timeout     <= 1'b1;
          end else if (r_wait_cnt != '0) begin
            r_wait_cnt    <= r_wait_cnt - LP_ONE;
            r_stretch_cnt <= r_stretch_cnt + LP_ONE;
            r_stretching  <= 1'b1;
          end else if (!w_mrdy_s) begin
            r_stretch_cnt <= r_stretch_cnt + LP_ONE;
            r_stretching  <= 1'b1;
          end else begin
            r_phase       <= PH_P0;
            r_cycle_start <= 1'b1;
          end
        end
        default: r_phase <= PH_P0;
      endcase
    end
  end

  assign eclk        = r_phase[1];
  assign qclk        = r_phase[0];
  assign cycle_start = r_cycle_start;
  assign stretching  = r_stretching;
  assign timeout     = r_timeout;

endmodule
